// File: rtl/blink_rate_checker_pkg.sv
// Shared types for the blink rate checker.
// State encodings and default clock rate.
package blink_rate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STUCK = 2'd2
  } state_t;

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam logic [15:0] GOOD_MAX = 16'hFFFF;

endpackage

// File: rtl/blink_rate_checker_sync_edge_detect.sv
// Two-flop synchroniser plus registered copy.
// Emits a one-cycle pulse on either edge of the line.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      s1         <= async_in;
      s2         <= s1;
      s3         <= s2;
      edge_pulse <= s2 ^ s3;
    end
  end

  assign sync_out = s2;

endmodule

// File: rtl/blink_rate_checker.sv
// Measures blink half-periods against EXP +/- TOL
// and flags a stuck line.
module blink_rate_checker
  import blink_rate_checker_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int TOL    = 1000,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blink_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             in_tol,
  output logic             fault,
  output logic [15:0]      good_count
);

  localparam int EXP = CLK_HZ / 2;
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(EXP + TOL);
  localparam logic [CNT_W:0] EXP_X =
    (CNT_W+1)'(EXP);
  localparam logic signed [CNT_W:0] TOL_X =
    (CNT_W+1)'(TOL);

  state_t state_q, state_d;

  logic             edge_p;
  logic             line_unused;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   meas;
  logic signed [CNT_W:0] diff, mag;
  logic tmo, ok;
  logic do_meas, go_stuck, go_track;

  sync_edge_detect u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (blink_in),
    .sync_out   (line_unused),
    .edge_pulse (edge_p)
  );

  // meas is the distance this edge would report;
  // timeout fires on the cycle it reaches the limit
  assign meas = {1'b0, cnt} + (CNT_W+1)'(1);
  assign tmo  = (meas == {1'b0, LIM});
  assign diff = $signed(meas) - $signed(EXP_X);
  assign mag  = diff[CNT_W] ? -diff : diff;
  assign ok   = (mag <= TOL_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_p) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edge_p) state_d = ST_TRACK;
        else if (tmo) state_d = ST_STUCK;
      end
      ST_TRACK: begin
        if (!edge_p && tmo) state_d = ST_STUCK;
      end
      ST_STUCK: begin
        if (edge_p) state_d = ST_TRACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    do_meas  = 1'b0;
    go_stuck = 1'b0;
    go_track = 1'b0;
    unique case (1'b1)
      (state_q == ST_TRACK): begin
        do_meas  = edge_p;
        go_stuck = !edge_p && tmo;
      end
      (state_q == ST_IDLE): begin
        go_stuck = !edge_p && tmo;
      end
      (state_q == ST_STUCK): begin
        go_track = edge_p;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_period <= '0;
      meas_valid  <= 1'b0;
      in_tol      <= 1'b0;
      fault       <= 1'b0;
      good_count  <= '0;
    end else begin
      meas_valid <= do_meas;
      if (do_meas) begin
        half_period <= meas[CNT_W-1:0];
        in_tol      <= ok;
        if (ok && good_count != GOOD_MAX)
          good_count <= good_count + 16'd1;
      end
      if (go_stuck) begin
        fault  <= 1'b1;
        in_tol <= 1'b0;
      end
      if (go_track) fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_rate_checker.sv
// Directed bench for blink_rate_checker.
// CLK_HZ=1000, TOL=5 -> EXP=500, 10 ns clock.
`timescale 1ns/1ps
module tb_blink_rate_checker;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             blink_in;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             in_tol;
  logic             fault;
  logic [15:0]      good_count;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int mv0;

  always #5 clk = ~clk;

  blink_rate_checker #(
    .CLK_HZ (1000),
    .TOL    (5),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blink_in    (blink_in),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .in_tol      (in_tol),
    .fault       (fault),
    .good_count  (good_count)
  );

  always @(negedge clk)
    if (meas_valid === 1'b1) mv_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // toggles land exactly gap cycles after the previous call's toggle
  task automatic gap_to(input int gap);
    repeat (gap - 6) @(negedge clk);
    blink_in = ~blink_in;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hp", 32'(half_period), 0);
    chk("rst_mv", 32'(meas_valid), 0);
    chk("rst_tol", 32'(in_tol), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_gc", 32'(good_count), 0);
    rst_n = 1'b1;

    // 1: six toggles 500 apart
    gap_to(100);
    chk("t1_first_nomv", 32'(mv_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      gap_to(500);
      chk("t1_hp", 32'(half_period), 500);
    end
    chk("t1_mv", 32'(mv_cnt), 5);
    chk("t1_tol", 32'(in_tol), 1);
    chk("t1_gc", 32'(good_count), 5);
    chk("t1_fault", 32'(fault), 0);

    // 2: boundary gaps
    gap_to(495);
    chk("t2_hp495", 32'(half_period), 495);
    chk("t2_tol495", 32'(in_tol), 1);
    gap_to(505);
    chk("t2_hp505", 32'(half_period), 505);
    chk("t2_tol505", 32'(in_tol), 1);
    gap_to(494);
    chk("t2_hp494", 32'(half_period), 494);
    chk("t2_tol494", 32'(in_tol), 0);
    chk("t2_gc", 32'(good_count), 7);
    chk("t2_fault", 32'(fault), 0);
    chk("t2_mv", 32'(mv_cnt), 8);

    // 3: stuck line, recovery
    repeat (502) @(negedge clk);
    chk("t3_fault_early", 32'(fault), 0);
    @(negedge clk);
    chk("t3_fault_set", 32'(fault), 1);
    chk("t3_tol", 32'(in_tol), 0);
    chk("t3_nomv", 32'(mv_cnt), 8);
    gap_to(100);
    chk("t3_fault_clr", 32'(fault), 0);
    chk("t3_nomv2", 32'(mv_cnt), 8);
    gap_to(500);
    chk("t3_hp", 32'(half_period), 500);
    chk("t3_tol_ok", 32'(in_tol), 1);
    chk("t3_mv", 32'(mv_cnt), 9);

    // 4: two edges 3 cycles apart
    repeat (494) @(negedge clk);
    blink_in = ~blink_in;
    repeat (3) @(negedge clk);
    blink_in = ~blink_in;
    repeat (8) @(negedge clk);
    chk("t4_mv", 32'(mv_cnt), 11);
    chk("t4_hp", 32'(half_period), 3);
    chk("t4_tol", 32'(in_tol), 0);
    chk("t4_gc", 32'(good_count), 9);

    // 5: async reset mid half-period
    repeat (240) @(negedge clk);
    #3;
    rst_n    = 1'b0;
    blink_in = 1'b0;
    #1;
    chk("t5_hp", 32'(half_period), 0);
    chk("t5_tol", 32'(in_tol), 0);
    chk("t5_fault", 32'(fault), 0);
    chk("t5_gc", 32'(good_count), 0);
    chk("t5_mvo", 32'(meas_valid), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    mv0 = mv_cnt;
    gap_to(500);
    chk("t5_first_nomv", 32'(mv_cnt - mv0), 0);
    chk("t5_hp_hold", 32'(half_period), 0);
    gap_to(500);
    chk("t5_mv", 32'(mv_cnt - mv0), 1);
    chk("t5_hp2", 32'(half_period), 500);
    chk("t5_gc2", 32'(good_count), 1);

    // 6: idle timeout, good_count saturation
    rst_n    = 1'b0;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (504) @(negedge clk);
    chk("t6_fault_early", 32'(fault), 0);
    @(negedge clk);
    chk("t6_fault_set", 32'(fault), 1);
    mv0 = mv_cnt;
    gap_to(100);
    chk("t6_fault_clr", 32'(fault), 0);
    chk("t6_nomv", 32'(mv_cnt - mv0), 0);
    force dut.good_count = 16'hFFFE;
    @(negedge clk);
    release dut.good_count;
    chk("t6_gc_forced", 32'(good_count), 32'hFFFE);
    gap_to(500);
    chk("t6_gc_max", 32'(good_count), 32'hFFFF);
    gap_to(500);
    chk("t6_gc_hold", 32'(good_count), 32'hFFFF);
    chk("t6_mv", 32'(mv_cnt - mv0), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
